// File: rtl/gray_cnt_ctrl.sv
// Start/stop/clear controlled binary counter with a Gray-coded output.
// It offers one-shot or periodic terminal-count modes and registered done/wrap/busy flags.
module gray_cnt_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset_al_in,
    input  logic         start_in,
    input  logic         stop_in,
    input  logic         clear_in,
    input  logic         mode_in,
    input  logic [N-1:0] target_in,
    output logic [N-1:0] gray_out,
    output logic         busy_out,
    output logic         done_out,
    output logic         wrap_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [N-1:0] BIN_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state_reg, state_next;
    logic [N-1:0] bin_reg, bin_next;
    logic [N-1:0] target_reg, target_next;
    logic         mode_reg, mode_next;
    logic         busy_reg, busy_next;
    logic         done_reg, done_next;
    logic         wrap_reg, wrap_next;
    logic         at_target;
    logic         at_max;

    assign at_target = (bin_reg == target_reg);
    assign at_max    = &bin_reg;

    // Command priority is clear > stop > start. Stop is only meaningful in RUN.
    // Start is only meaningful outside RUN.
    always_comb begin
        state_next  = state_reg;
        bin_next    = bin_reg;
        target_next = target_reg;
        mode_next   = mode_reg;
        done_next   = 1'b0;
        wrap_next   = 1'b0;
        if (clear_in) begin
            state_next = ST_IDLE;
            bin_next   = '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start_in) begin
                        target_next = target_in;
                        mode_next   = mode_in;
                        bin_next    = '0;
                        state_next  = ST_RUN;
                    end
                end
                ST_HOLD: begin
                    if (start_in) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A stop that lands on the terminal match defers the done pulse until after resume.
                    if (stop_in) begin
                        state_next = ST_HOLD;
                    end else if (at_target) begin
                        done_next = 1'b1;
                        if (mode_reg) begin
                            bin_next = '0;
                        end else begin
                            state_next = ST_DONE;
                        end
                    end else begin
                        bin_next  = bin_reg + BIN_ONE;
                        wrap_next = at_max;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
        busy_next = (state_next == ST_RUN) || (state_next == ST_HOLD);
    end

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state_reg  <= ST_IDLE;
            bin_reg    <= '0;
            target_reg <= '0;
            mode_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            wrap_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            bin_reg    <= bin_next;
            target_reg <= target_next;
            mode_reg   <= mode_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            wrap_reg   <= wrap_next;
        end
    end

    // Gray conversion is pure wiring from the count register, so it adds no latency.
    genvar gi;
    generate
        for (gi = 0; gi < N - 1; gi++) begin : g_gray
            assign gray_out[gi] = bin_reg[gi] ^ bin_reg[gi+1];
        end
    endgenerate
    assign gray_out[N-1] = bin_reg[N-1];

    assign busy_out = busy_reg;
    assign done_out = done_reg;
    assign wrap_out = wrap_reg;

endmodule

// File: tb/tb_gray_cnt_ctrl.sv
// Scoreboard bench for gray_cnt_ctrl: N=4 and N=8 instances share one command stream.
// Expectations come from a behavioural model and are checked by an independent monitor.
module tb_gray_cnt_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_al_in = 1'b0;
    logic       start_in = 1'b0, stop_in = 1'b0, clear_in = 1'b0, mode_in = 1'b0;
    logic [3:0] target4 = '0;
    logic [7:0] target8 = '0;
    logic [3:0] gray4;
    logic [7:0] gray8;
    logic       busy4, done4, wrap4, busy8, done8, wrap8;

    gray_cnt_ctrl #(.N(4)) dut4 (
        .clk(clk), .reset_al_in(reset_al_in), .start_in(start_in), .stop_in(stop_in),
        .clear_in(clear_in), .mode_in(mode_in), .target_in(target4),
        .gray_out(gray4), .busy_out(busy4), .done_out(done4), .wrap_out(wrap4)
    );

    gray_cnt_ctrl #(.N(8)) dut8 (
        .clk(clk), .reset_al_in(reset_al_in), .start_in(start_in), .stop_in(stop_in),
        .clear_in(clear_in), .mode_in(mode_in), .target_in(target8),
        .gray_out(gray8), .busy_out(busy8), .done_out(done8), .wrap_out(wrap8)
    );

    localparam int PH_IDLE = 0, PH_RUN = 1, PH_HOLD = 2, PH_DONE = 3;

    typedef struct {
        int phase;
        int bin;
        int tgt;
        bit periodic;
        bit busy;
        bit done;
        bit wrap;
    } mdl_t;

    typedef struct {
        int gray;
        bit busy;
        bit done;
        bit wrap;
    } exp_t;

    mdl_t m4, m8;
    exp_t q4[$], q8[$];
    int   checks = 0, failures = 0;
    bit   stim_active = 1'b0;
    bit   gray_walk = 1'b0;

    // Behavioural reference: one clock of the counter's rules, applied to plain integers.
    function automatic mdl_t mstep(mdl_t m, int n, bit rst_n, bit st, bit sp, bit cl, bit md, int tg);
        mdl_t r;
        int   modulus = 1 << n;
        r      = m;
        r.done = 1'b0;
        r.wrap = 1'b0;
        if (!rst_n) begin
            r = '{default: 0};
            return r;
        end
        if (cl) begin
            r.phase = PH_IDLE;
            r.bin   = 0;
        end else if (m.phase == PH_RUN && sp) begin
            r.phase = PH_HOLD;
        end else if ((m.phase == PH_IDLE || m.phase == PH_DONE) && st) begin
            r.phase    = PH_RUN;
            r.tgt      = tg % modulus;
            r.periodic = md;
            r.bin      = 0;
        end else if (m.phase == PH_HOLD && st) begin
            r.phase = PH_RUN;
        end else if (m.phase == PH_RUN) begin
            if (m.bin == m.tgt) begin
                r.done = 1'b1;
                if (m.periodic) r.bin = 0;
                else            r.phase = PH_DONE;
            end else begin
                r.wrap = (m.bin + 1 >= modulus);
                r.bin  = (m.bin + 1) % modulus;
            end
        end
        r.busy = (r.phase == PH_RUN || r.phase == PH_HOLD);
        return r;
    endfunction

    function automatic int to_gray(int b, int n);
        int g = 0;
        for (int i = 0; i < n; i++) begin
            if (((b >> i) & 1) != ((b >> (i + 1)) & 1)) g += (1 << i);
        end
        return g;
    endfunction

    function automatic exp_t expect_of(mdl_t m, int n);
        exp_t e;
        e.gray = to_gray(m.bin, n);
        e.busy = m.busy;
        e.done = m.done;
        e.wrap = m.wrap;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, step the model at the rising edge, queue the expectation.
    task automatic cyc(input bit st, input bit sp, input bit cl, input bit md, input int t4, input int t8);
        start_in = st;
        stop_in  = sp;
        clear_in = cl;
        mode_in  = md;
        target4  = t4[3:0];
        target8  = t8[7:0];
        @(posedge clk);
        m4 = mstep(m4, 4, reset_al_in, st, sp, cl, md, t4);
        m8 = mstep(m8, 8, reset_al_in, st, sp, cl, md, t8);
        q4.push_back(expect_of(m4, 4));
        q8.push_back(expect_of(m8, 8));
        @(negedge clk);
    endtask

    // Idle cycles with junk on target/mode, which must not disturb a run in progress.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
    endtask

    task automatic async_reset();
        #2 reset_al_in = 1'b0;
        #1;
        check("rst_async_gray4", 32'(gray4), 32'd0);
        check("rst_async_busy4", 32'(busy4), 32'd0);
        check("rst_async_gray8", 32'(gray8), 32'd0);
        check("rst_async_busy8", 32'(busy8), 32'd0);
        check("rst_async_done8", 32'(done8), 32'd0);
        check("rst_async_wrap8", 32'(wrap8), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        reset_al_in = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Monitor: pops one expectation per DUT per clock and compares all outputs.
    initial begin
        exp_t       e4, e8;
        logic [7:0] prev8 = '0;
        bit         have_prev = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (stim_active) begin
                if (q4.size() == 0 || q8.size() == 0) begin
                    check("sb_underflow", 32'(q4.size() + q8.size()), 32'd2);
                end else begin
                    e4 = q4.pop_front();
                    e8 = q8.pop_front();
                    check("gray4", 32'(gray4), 32'(e4.gray));
                    check("busy4", 32'(busy4), 32'(e4.busy));
                    check("done4", 32'(done4), 32'(e4.done));
                    check("wrap4", 32'(wrap4), 32'(e4.wrap));
                    check("gray8", 32'(gray8), 32'(e8.gray));
                    check("busy8", 32'(busy8), 32'(e8.busy));
                    check("done8", 32'(done8), 32'(e8.done));
                    check("wrap8", 32'(wrap8), 32'(e8.wrap));
                end
            end
            if (gray_walk) begin
                if (have_prev && gray8 != prev8)
                    check("gray8_one_bit_step", 32'($countones(gray8 ^ prev8)), 32'd1);
                prev8     = gray8;
                have_prev = 1'b1;
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sel, t4, t8;
        m4 = '{default: 0};
        m8 = '{default: 0};
        #1;
        check("rst_gray4", 32'(gray4), 32'd0);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check("rst_gray8", 32'(gray8), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_al_in = 1'b1;
        stim_active = 1'b1;
        idle(3);

        // One-shot to 5, then periodic to 2.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5, 5);
        idle(9);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 2, 2);
        idle(10);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);

        // Full-range target, one-shot then periodic.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 15, 15);
        idle(18);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 15, 15);
        idle(36);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);

        // Pause at bin 3, resume, then all commands together.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 10, 10);
        idle(3);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        idle(10);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        idle(2);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
        idle(2);

        // Stop that coincides with the terminal match.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 2, 2);
        idle(2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        idle(3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        idle(3);

        // Zero target in both modes.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        idle(3);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
        idle(5);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);

        // Asynchronous reset with the 8-bit count at 9.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 12, 200);
        idle(9);
        async_reset();

        // Full 8-bit walk, one Gray bit per step.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 15, 255);
        gray_walk = 1'b1;
        idle(258);
        gray_walk = 1'b0;

        // Random commands with biased targets.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                sel = int'($urandom_range(0, 3));
                t4  = (sel == 0) ? 0 : (sel == 1) ? 15 : (sel == 2) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 15));
                t8  = (sel == 0) ? 0 : (sel == 1) ? 255 : (sel == 2) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 255));
                cyc($urandom_range(0, 99) < 12, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2,
                    1'($urandom_range(0, 1)), t4, t8);
            end
        end

        stim_active = 1'b0;
        @(posedge clk);
        #3;
        check("sb_leftover", 32'(q4.size() + q8.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_cnt_ctrl.md
GRAY_CNT_CTRL -- requirements
Module: gray_cnt_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the counter width in bits (N >= 2).
REQ-002 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-003 Port reset_al_in, input, 1 bit: reset SHALL be asynchronous and active-low; it SHALL act on the falling edge with no clock required.
REQ-004 Port start_in, input, 1 bit: start a run, or resume a held run.
REQ-005 Port stop_in, input, 1 bit: pause a run.
REQ-006 Port clear_in, input, 1 bit: abort and zero the count.
REQ-007 Port mode_in, input, 1 bit: 0 = one-shot, 1 = periodic; SHALL be sampled with target_in.
REQ-008 Port target_in, input, N bits: binary terminal count.
REQ-009 Port gray_out, output, N bits: Gray-coded count.
REQ-010 Port busy_out, output, 1 bit: high while state is RUN or HOLD.
REQ-011 Port done_out, output, 1 bit: one-cycle pulse on terminal count.
REQ-012 Port wrap_out, output, 1 bit: one-cycle pulse on binary rollover.

Function
REQ-013 The block SHALL hold an internal N-bit binary count bin and a 4-state FSM: IDLE, RUN, HOLD, DONE.
REQ-014 gray_out SHALL equal bin ^ (bin >> 1) at all times, with MSB = bin[N-1], and no added latency relative to bin.
REQ-015 When start_in is sampled in IDLE or DONE, the block SHALL: latch target_in into target_q, latch mode_in into mode_q, set bin <= 0, and go to RUN.
REQ-016 In RUN with bin != target_q, bin SHALL increment by 1 every clock, modulo 2^N.
REQ-017 In RUN with bin == target_q and mode_q = 0, the block SHALL go to DONE, hold bin, and pulse done_out.
REQ-018 In RUN with bin == target_q and mode_q = 1, the block SHALL set bin <= 0, stay in RUN, and pulse done_out.
REQ-019 In RUN with bin = 2^N-1 and target_q != 2^N-1, bin SHALL roll over to 0 and wrap_out SHALL pulse; the target match takes precedence over rollover.
REQ-020 stop_in in RUN SHALL move the FSM to HOLD with bin frozen; start_in in HOLD SHALL resume RUN without reloading target_q, mode_q or bin.
REQ-021 clear_in in any state SHALL force IDLE and bin <= 0; no done_out or wrap_out pulse SHALL be produced.
REQ-022 Command priority SHALL be clear_in > stop_in > start_in; start_in in RUN and stop_in outside RUN SHALL be ignored.
REQ-023 If stop_in coincides with a terminal match in RUN, the FSM SHALL go to HOLD, bin SHALL freeze at target_q, and done_out SHALL NOT pulse; the pulse occurs on the match evaluated after resume.
REQ-024 target_q = 0 in one-shot mode SHALL reach DONE on the first clock after entering RUN; in periodic mode bin SHALL stay at 0 and done_out SHALL stay high every cycle.
REQ-025 done_out and wrap_out SHALL be registered, asserted in the cycle after the decision edge, and held for exactly one cycle per event.
REQ-026 busy_out SHALL be registered and derived from the next state.
REQ-027 In IDLE and DONE, bin SHALL hold its value.
REQ-028 Changes to target_in or mode_in during RUN or HOLD SHALL have no effect.

Reset
REQ-029 When reset_al_in is low, the block SHALL force state = IDLE, and all N bits of bin, target_q and mode_q to 0.
REQ-030 Reset SHALL force gray_out = 0, busy_out = 0, done_out = 0 and wrap_out = 0, including when asserted mid-run.
REQ-031 After reset_al_in deasserts, the block SHALL remain in IDLE until start_in is sampled high.

Verification (N=4 unless stated)
REQ-032 One-shot count: target 5, mode 0, start pulse -> gray_out steps 0,1,3,2,6,7; done_out pulses once; state DONE; gray_out stays 7.
REQ-033 Periodic count: target 2, mode 1 -> bin sequence 0,1,2,0,1,2...; done_out pulses every 3rd cycle; busy_out stays 1.
REQ-034 Rollover: target 15 with N=4 -> no wrap_out pulse and done at gray 8; then N=4, target 15, mode 1 -> bin returns to 0 via the match, wrap_out stays 0.
REQ-035 Pause and priority: stop_in at bin=3 -> bin holds for 10 cycles; start_in resumes from 4; clear_in+stop_in+start_in together -> IDLE, bin 0.
REQ-036 Reset mid-run: reset_al_in low asynchronously at bin=9 with N=8 -> all 8 bits of gray_out = 0 immediately, busy_out = 0, no pulses.
REQ-037 Exhaustive Gray check: N=8, target 255, mode 0 -> every successive gray_out pair differs in exactly one bit over 256 steps.
